// File: rtl/mux_2x1.sv
// Signed 2:1 word mux for datapath steering; combinational by default.
// Define MUX_2X1_OUT_REG_EN to register Y (sync active-high reset to 0).
module mux_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic signed [WIDTH-1:0] Y,
  input  logic                    S,
  input  logic signed [WIDTH-1:0] I0,
  input  logic signed [WIDTH-1:0] I1
);

  // Ternary keeps agreeing bits known when S is X/Z
  logic signed [WIDTH-1:0] sel;
  assign sel = S ? I1 : I0;

`ifdef MUX_2X1_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) Y <= '0;
    else     Y <= sel;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign Y = sel;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Directed self-checking bench for mux_2x1 (WIDTH=32).
// Covers the default build, or the registered build under MUX_2X1_OUT_REG_EN.
module tb_mux_2x1;

  localparam int W = 32;

  logic                clk;
  logic                rst;
  logic                S;
  logic signed [W-1:0] I0;
  logic signed [W-1:0] I1;
  logic signed [W-1:0] Y;

  int vectors = 0;
  int errs    = 0;

  mux_2x1 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .Y  (Y),
    .S  (S),
    .I0 (I0),
    .I1 (I1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string               tag,
    input logic signed [W-1:0] obs,
    input logic signed [W-1:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d (%h) expected %0d (%h)",
             tag, obs, obs, exp, exp);
    end
  endtask

  initial begin
`ifndef MUX_2X1_OUT_REG_EN
    rst = 1'b1;
    S  = 1'b0;
    I0 = -32'sd12;
    I1 = 32'sd120;
    #1 check("init_in_reset", Y, -32'sd12);
    rst = 1'b0;
    #4;
    S = 1'b1; I0 = -32'sd11; I1 = 32'sd121;
    #1 check("toggle1", Y, 32'sd121);
    #4;
    S = 1'b0; I0 = -32'sd10; I1 = 32'sd122;
    #1 check("toggle2", Y, -32'sd10);
    #4;
    S = 1'b1; I0 = -32'sd9; I1 = 32'sd123;
    #1 check("toggle3", Y, 32'sd123);
    #4;
    S = 1'b0; I0 = -32'sd8; I1 = 32'sd124;
    #1 check("toggle4", Y, -32'sd8);
    #4;
    S = 1'b1; I0 = -32'sd7; I1 = 32'sd125;
    #1 check("toggle5", Y, 32'sd125);
    #4;
    S = 1'b0; I0 = 32'h8000_0000; I1 = 32'h7FFF_FFFF;
    #1 check("min_s0", Y, 32'h8000_0000);
    S = 1'b1;
    #1 check("max_s1", Y, 32'h7FFF_FFFF);
    S = 1'b0; I0 = 32'hA5A5_5A5A; I1 = 32'h5A5A_A5A5;
    #1 check("pattern_s0", Y, 32'hA5A5_5A5A);
    S = 1'b1;
    #1 check("pattern_s1", Y, 32'h5A5A_A5A5);
    // S and both data words change together
    S = 1'b0; I0 = 32'sd42; I1 = -32'sd42;
    #1 check("simul_change", Y, 32'sd42);
    S = 1'bx; I0 = 32'sd5; I1 = 32'sd5;
    #1 check("sel_x_agree", Y, 32'sd5);
    I0 = 32'sd0; I1 = 32'sd1;
    #1 check("sel_x_upper", {1'b0, Y[W-1:1]}, 32'sd0);
    rst = 1'b1; S = 1'b1; I1 = 32'sd7;
    #1 check("rst_indep", Y, 32'sd7);
    @(posedge clk); #1;
    check("rst_edge_indep", Y, 32'sd7);
    rst = 1'b0; I1 = -32'sd1;
    @(posedge clk); #1;
    check("after_rst", Y, -32'sd1);
`else
    rst = 1'b1; S = 1'b0; I0 = 32'sd11; I1 = 32'sd22;
    @(posedge clk); @(posedge clk); #1;
    check("reset_2edges", Y, 32'sd0);
    @(negedge clk);
    rst = 1'b0; S = 1'b0; I0 = -32'sd3;
    #1 check("no_early_load", Y, 32'sd0);
    @(posedge clk); #1;
    check("load_m3", Y, -32'sd3);
    @(negedge clk);
    S = 1'b1; I1 = 32'h7FFF_FFFF;
    #1 check("hold_between", Y, -32'sd3);
    @(posedge clk); #1;
    check("load_max", Y, 32'h7FFF_FFFF);
    @(negedge clk);
    S = 1'b0; I0 = 32'h8000_0000;
    @(posedge clk); #1;
    check("load_min", Y, 32'h8000_0000);
    @(negedge clk);
    S = 1'b1; I0 = 32'hA5A5_5A5A; I1 = 32'h5A5A_A5A5;
    @(posedge clk); #1;
    check("load_pattern", Y, 32'h5A5A_A5A5);
    @(negedge clk);
    rst = 1'b1; S = 1'b1; I1 = 32'sd9;
    #1 check("pre_rst_hold", Y, 32'h5A5A_A5A5);
    @(posedge clk); #1;
    check("rst_discard", Y, 32'sd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load", Y, 32'sd9);
    @(negedge clk);
    S = 1'b0; I0 = 32'sd5;
    @(posedge clk); #1;
    check("load_s0", Y, 32'sd5);
    @(negedge clk);
    S = 1'b1; I1 = -32'sd12;
    @(posedge clk); #1;
    check("load_neg", Y, -32'sd12);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
